ps2_scan_decoder: RTL
=====================

# ps2_scan_decoder

Scan-code decoder stage sitting directly downstream of the PS/2 byte receiver (`USBReader`). It consumes the receiver's one-cycle `word_ready` strobe and 8-bit byte, and strips set-2 prefixes (E0 extended, F0 break, E1 Pause). It emits one complete key event per key action into a small FIFO with a valid/ready handshake. It replaces ad-hoc F0 filtering in top-level glue, so display/string logic only ever sees whole make/break events.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `TIMEOUT_CYC`, default 2_000_000: cycles (20 ms at 100 MHz) a pending prefix survives without a following byte.
- `SUPPRESS_REPEAT`, default 1: 1 drops typematic repeat makes of the currently held key.

Ports:
- `ck`, in, 1: system clock (100 MHz).
- `reset`, in, 1: reset, asynchronous, active-high.
- `byte_valid`, in, 1: one-cycle strobe from the receiver, synchronous to `ck`.
- `byte_data`, in, 8: received scan byte; sampled only when `byte_valid` is high.
- `ev_valid`, out, 1: FIFO head holds an event.
- `ev_ready`, in, 1: consumer accepts the head when `ev_valid` and `ev_ready` are both high.
- `ev_code`, out, 8: base scan code of the head event.
- `ev_ext`, out, 1: event carried an E0 or E1 prefix.
- `ev_brk`, out, 1: event is a release (break).
- `ev_count`, out, clog2(DEPTH)+1: FIFO occupancy.
- `ovf`, out, 1: sticky flag; set when an event is dropped because the FIFO is full; cleared only by reset.

## Operation
- Prefix FSM states: IDLE, E0, F0, E0F0, PAUSE. All transitions happen only on `byte_valid`, except the timeout.
- **IDLE**
  - E0 → E0.
  - F0 → F0.
  - E1 → PAUSE, loading skip count 7.
  - Control bytes 00, AA, EE, FA, FC, FE, FF are dropped; stay in IDLE.
  - Any other byte: emit {code, ext=0, brk=0}.
- **E0**
  - F0 → E0F0.
  - 12 is a fake shift: drop it and return to IDLE.
  - Other bytes: emit {code, 1, 0} and go to IDLE.
- **F0**: emit {code, 0, 1} and go to IDLE.
- **E0F0**
  - 12 → drop and go to IDLE.
  - Otherwise emit {code, 1, 1} and go to IDLE.
- **PAUSE**
  - Decrement the skip count on each byte; bytes are not decoded.
  - When the count reaches 0, emit {77, 1, 0} and go to IDLE.
  - No break is ever emitted for Pause.
- **Timeout**
  - Counter clears on every `byte_valid` and runs while the state is not IDLE.
  - Reaching TIMEOUT_CYC forces IDLE with no emit; this discards a partial sequence.
- **Repeat suppression** (SUPPRESS_REPEAT=1)
  - A `held` register {valid, code, ext} is loaded on every emitted make.
  - A make equal to `held` is dropped.
  - A break matching `held` clears `held.valid`.
  - Breaks and Pause are never suppressed.
- **FIFO**
  - Circular buffer; entry width is 10 bits.
  - A push into a full FIFO with no simultaneous pop is dropped and sets `ovf`.
  - A push and a pop in the same cycle on a full FIFO both succeed; occupancy is unchanged.
  - A push and a pop on an empty FIFO: the push is stored and `ev_valid` rises the next cycle. There is no bypass.
  - The head outputs are stable while `ev_valid` is high and `ev_ready` is low.
- **Reset**
  - Values: state IDLE, FIFO empty, `ev_valid`=0, `ev_code`=00, `ev_ext`=0, `ev_brk`=0, `ev_count`=0, `ovf`=0, `held.valid`=0, timeout counter 0.
  - A reset asserted mid-sequence discards the prefix and all queued events.

## Timing
- Decode latency: for a `byte_valid` in cycle N that completes an event, the entry is written at the edge ending cycle N. With the FIFO empty, `ev_valid`=1 and the head outputs are valid in cycle N+1.
- Pop: the handshake in cycle M presents the next entry, or drops `ev_valid`, in cycle M+1.
- At most one event per `byte_valid`. The receiver spacing (≥1 PS/2 frame, ≈1 ms) guarantees no back-to-back strobes; the block must still process strobes on consecutive cycles correctly.
- Timeout: a prefix with no follow-up byte for exactly TIMEOUT_CYC cycles is discarded. A follow-up arriving at TIMEOUT_CYC−1 cycles completes the event.

## Test plan
- Bytes 1C, F0 1C → event {1C,0,0} at N+1, then event {1C,0,1}; `ev_count` peaks at 2 with `ev_ready`=0.
- Bytes E0 12 E0 75, then E0 F0 75 E0 F0 12 → exactly two events: {75,1,0} and {75,1,1}.
- E1 14 77 E1 F0 14 F0 77 → single event {77,1,0}; a following 1C decodes normally.
- Typematic: 1C ×5 then F0 1C → {1C,0,0} and {1C,0,1} only. With SUPPRESS_REPEAT=0 → five makes plus one break.
- Hold `ev_ready`=0 and send 6 makes of distinct codes with DEPTH=4 → `ev_count`=4 and `ovf`=1; the popped order matches the first four codes. A simultaneous push and pop when full keeps the count at 4 and leaves `ovf` unchanged.
- Timeout and reset:
  - E0, then wait TIMEOUT_CYC, then 75 → event {75,0,0}.
  - F0, then reset, then 1C → {1C,0,0}; all outputs read zero during reset.

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code decoder: folds E0/F0/E1 prefixes into whole make/break events and queues them.
// One-cycle decode into the FIFO (no bypass); the consumer pops with ev_valid/ev_ready, and pushes into a full FIFO are dropped and set ovf.

module ps2_ev_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   ck,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_rdy,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_pop   = pop_vld && pop_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_rdy = (count != FULL_CNT) || do_pop;
  assign do_push  = push_vld && push_rdy;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end
endmodule

module ps2_scan_decoder #(
  parameter int DEPTH           = 4,
  parameter int TIMEOUT_CYC     = 2_000_000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic                   ck,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [7:0]             ev_code,
  output logic                   ev_ext,
  output logic                   ev_brk,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   ovf
);
  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  state_t      state, state_nxt;
  logic [2:0]  skip_cnt, skip_nxt;
  logic [TW-1:0] tmo_cnt;
  logic        tmo_hit;
  logic        is_ctrl;
  ev_t         dec_ev;
  logic        dec_vld, dec_pause;
  logic        held_v, held_e, held_hit;
  logic [7:0]  held_c;
  logic        push_vld, push_rdy;
  ev_t         head;

  assign is_ctrl = byte_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  // tmo_cnt is (cycles since the last byte) - 1, so the hit lands in the
  // last cycle in which a follow-up byte is still accepted.
  assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    dec_vld   = 1'b0;
    dec_pause = 1'b0;
    dec_ev    = '{code: byte_data, ext: 1'b0, brk: 1'b0};
    if (byte_valid) begin
      case (state)
        S_IDLE: begin
          if (byte_data == 8'hE0) state_nxt = S_E0;
          else if (byte_data == 8'hF0) state_nxt = S_F0;
          else if (byte_data == 8'hE1) begin
            state_nxt = S_PAUSE;
            skip_nxt  = 3'd7;
          end else if (!is_ctrl) dec_vld = 1'b1;
        end
        S_E0: begin
          if (byte_data == 8'hF0) state_nxt = S_E0F0;
          else begin
            state_nxt  = S_IDLE;
            dec_vld    = (byte_data != 8'h12);
            dec_ev.ext = 1'b1;
          end
        end
        S_F0: begin
          state_nxt  = S_IDLE;
          dec_vld    = 1'b1;
          dec_ev.brk = 1'b1;
        end
        S_E0F0: begin
          state_nxt  = S_IDLE;
          dec_vld    = (byte_data != 8'h12);
          dec_ev.ext = 1'b1;
          dec_ev.brk = 1'b1;
        end
        S_PAUSE: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            state_nxt = S_IDLE;
            dec_vld   = 1'b1;
            dec_pause = 1'b1;
            dec_ev    = '{code: 8'h77, ext: 1'b1, brk: 1'b0};
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      if (byte_valid || state == S_IDLE) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  assign held_hit = held_v && (held_c == dec_ev.code) && (held_e == dec_ev.ext);
  assign push_vld = dec_vld &&
                    !(SUPPRESS_REPEAT && !dec_ev.brk && !dec_pause && held_hit);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      held_v <= 1'b0;
      held_c <= '0;
      held_e <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (dec_vld && !dec_ev.brk) begin
        held_v <= 1'b1;
        held_c <= dec_ev.code;
        held_e <= dec_ev.ext;
      end else if (dec_vld && held_hit) begin
        held_v <= 1'b0;
      end
      if (push_vld && !push_rdy) ovf <= 1'b1;
    end
  end

  ps2_ev_fifo #(.WIDTH($bits(ev_t)), .DEPTH(DEPTH)) u_fifo (
    .ck       (ck),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (dec_ev),
    .push_rdy (push_rdy),
    .pop_vld  (ev_valid),
    .pop_rdy  (ev_ready),
    .pop_dat  (head),
    .count    (ev_count)
  );

  assign ev_code = head.code;
  assign ev_ext  = head.ext;
  assign ev_brk  = head.brk;
endmodule
